// File: rtl/multicycle_controller.sv
// Control unit for a multicycle MIPS-style datapath: a Moore state machine
// sequencing fetch/decode/execute, plus the ALU-control decoder.
module multicycle_controller #(
  parameter int BNE_EN = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcen,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BEQ    = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JMP    = 4'd11,
    BNE    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Plain vector register so unused codes 13-15 are representable and recover.
  logic [3:0] r_state;

  logic       w_pcwrite;
  logic       w_branch;
  logic       w_branchn;
  logic [1:0] w_aluop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= FETCH;
    end else begin
      case (r_state)
        FETCH:  r_state <= DECODE;
        DECODE: begin
          case (op)
            OP_LW, OP_SW: r_state <= MEMADR;
            OP_RTYPE:     r_state <= EXEC;
            OP_BEQ:       r_state <= BEQ;
            OP_BNE:       r_state <= (BNE_EN != 0) ? BNE : FETCH;
            OP_ADDI:      r_state <= ADDIEX;
            OP_J:         r_state <= JMP;
            default:      r_state <= FETCH;
          endcase
        end
        // Op is sampled again here to pick the load or store path.
        MEMADR: r_state <= (op == OP_SW) ? MEMWR : MEMRD;
        MEMRD:  r_state <= MEMWB;
        EXEC:   r_state <= ALUWB;
        ADDIEX: r_state <= ADDIWB;
        default: r_state <= FETCH;
      endcase
    end
  end

  always_comb begin
    iord      = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    regwrite  = 1'b0;
    regdst    = 1'b0;
    memtoreg  = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    pcsrc     = 2'b00;
    w_pcwrite = 1'b0;
    w_branch  = 1'b0;
    w_branchn = 1'b0;
    w_aluop   = 2'b00;
    case (r_state)
      FETCH: begin
        irwrite   = 1'b1;
        w_pcwrite = 1'b1;
        alusrcb   = 2'b01;
      end
      DECODE: alusrcb = 2'b11;
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: iord = 1'b1;
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      ADDIWB: regwrite = 1'b1;
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      EXEC: begin
        alusrca = 1'b1;
        w_aluop = 2'b10;
      end
      BEQ: begin
        alusrca  = 1'b1;
        w_aluop  = 2'b01;
        pcsrc    = 2'b01;
        w_branch = 1'b1;
      end
      BNE: begin
        alusrca   = 1'b1;
        w_aluop   = 2'b01;
        pcsrc     = 2'b01;
        w_branchn = 1'b1;
      end
      JMP: begin
        pcsrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign pcen  = w_pcwrite | (w_branch & zero) | (w_branchn & ~zero);
  assign state = r_state;

  always_comb begin
    alucontrol = 3'b010;
    case (w_aluop)
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed vector table, reset/corner
// sequences and random instruction streams against a behavioural model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;

  logic       iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  logic       iord0, memwrite0, irwrite0, pcen0, regwrite0, regdst0, memtoreg0, alusrca0;
  logic [1:0] alusrcb0, pcsrc0;
  logic [2:0] alucontrol0;
  logic [3:0] state0;

  int testsRun = 0;
  int testsFailed = 0;

  multicycle_controller #(.BNE_EN(1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .pcen(pcen),
    .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state)
  );

  multicycle_controller #(.BNE_EN(0)) dut0 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .iord(iord0), .memwrite(memwrite0), .irwrite(irwrite0), .pcen(pcen0),
    .regwrite(regwrite0), .regdst(regdst0), .memtoreg(memtoreg0), .alusrca(alusrca0),
    .alusrcb(alusrcb0), .pcsrc(pcsrc0), .alucontrol(alucontrol0), .state(state0)
  );

  always #5 clk = ~clk;

  wire [14:0] w_bundle = {iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg,
                          alusrca, alusrcb, pcsrc, alucontrol};

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic [3:0]  n;
    logic [19:0] seq;
    logic [3:0]  keySt;
    logic [2:0]  keyAlu;
    logic        keyPcen;
    logic        keyRw;
    logic        keyMw;
  } vec_t;

  vec_t vecs[16];
  logic [3:0]  expSt;
  logic [23:0] expSeq;
  logic [5:0]  functList[7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                6'b101010, 6'b000111, 6'b111111};

  // Behavioural model: ALU operation implied by an R-type function field.
  function automatic logic [2:0] functAlu(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected state trace for one instruction: count in [23:20], states from [19:16] down.
  function automatic logic [23:0] expStates(input logic [5:0] o, input bit bneEn);
    logic [3:0]  n;
    logic [19:0] s;
    n = 4'd2;
    s = 20'h01000;
    case (o)
      6'b100011: begin n = 4'd5; s[11:0] = 12'h234; end
      6'b101011: begin n = 4'd4; s[11:4] = 8'h25; end
      6'b000000: begin n = 4'd4; s[11:4] = 8'h67; end
      6'b000100: begin n = 4'd3; s[11:8] = 4'h8; end
      6'b000101: if (bneEn) begin n = 4'd3; s[11:8] = 4'hC; end
      6'b001000: begin n = 4'd4; s[11:4] = 8'h9A; end
      6'b000010: begin n = 4'd3; s[11:8] = 4'hB; end
      default: ;
    endcase
    return {n, s};
  endfunction

  // Expected output bundle for a given state, function field and zero flag.
  function automatic logic [14:0] expOut(input logic [3:0] st, input logic [5:0] f, input logic z);
    logic io, mw, irw, pe, rw, rd, m2r, sa;
    logic [1:0] sb, ps;
    logic [2:0] alu;
    {io, mw, irw, pe, rw, rd, m2r, sa} = 8'd0;
    sb = 2'b00; ps = 2'b00; alu = 3'b010;
    case (st)
      4'd0:       begin irw = 1; pe = 1; sb = 2'b01; end
      4'd1:       sb = 2'b11;
      4'd2, 4'd9: begin sa = 1; sb = 2'b10; end
      4'd3:       io = 1;
      4'd5:       begin io = 1; mw = 1; end
      4'd4:       begin m2r = 1; rw = 1; end
      4'd10:      rw = 1;
      4'd7:       begin rd = 1; rw = 1; end
      4'd6:       begin sa = 1; alu = functAlu(f); end
      4'd8:       begin sa = 1; ps = 2'b01; alu = 3'b110; pe = z; end
      4'd12:      begin sa = 1; ps = 2'b01; alu = 3'b110; pe = ~z; end
      4'd11:      begin ps = 2'b10; pe = 1; end
      default: ;
    endcase
    return {io, mw, irw, pe, rw, rd, m2r, sa, sb, ps, alu};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f);
    op = o;
    funct = f;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Runs one instruction from FETCH; zmode 0/1 fixes zero, 2 randomises it per cycle.
  task automatic runInstr(input logic [5:0] o, input logic [5:0] f, input int zmode);
    logic [23:0] q;
    logic [3:0]  s;
    applyStimulus(o, f);
    q = expStates(o, 1'b1);
    for (int i = 0; i < int'(q[23:20]); i++) begin
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
      #1;
      s = q[19-4*i -: 4];
      checkOutput("model_state", state, s);
      checkOutput("model_outputs", w_bundle, expOut(s, f, zero));
      checkOutput("memwrite_regwrite_excl", memwrite & regwrite, 0);
      checkOutput("irwrite_only_fetch", irwrite & (state != 4'd0), 0);
      @(negedge clk);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{6'b100011, 6'b100000, 1'b0, 4'd5, 20'h01234, 4'd4,  3'b010, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{6'b101011, 6'b100000, 1'b0, 4'd4, 20'h01250, 4'd5,  3'b010, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{6'b000000, 6'b100010, 1'b0, 4'd4, 20'h01670, 4'd6,  3'b110, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{6'b000000, 6'b101010, 1'b0, 4'd4, 20'h01670, 4'd6,  3'b111, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{6'b000000, 6'b100101, 1'b0, 4'd4, 20'h01670, 4'd6,  3'b001, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{6'b000000, 6'b100100, 1'b0, 4'd4, 20'h01670, 4'd6,  3'b000, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{6'b000000, 6'b100000, 1'b0, 4'd4, 20'h01670, 4'd6,  3'b010, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{6'b000000, 6'b110011, 1'b0, 4'd4, 20'h01670, 4'd6,  3'b010, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{6'b000000, 6'b100010, 1'b0, 4'd4, 20'h01670, 4'd7,  3'b010, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{6'b000100, 6'b000000, 1'b1, 4'd3, 20'h01800, 4'd8,  3'b110, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{6'b000100, 6'b000000, 1'b0, 4'd3, 20'h01800, 4'd8,  3'b110, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{6'b000101, 6'b000000, 1'b0, 4'd3, 20'h01C00, 4'd12, 3'b110, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{6'b000101, 6'b000000, 1'b1, 4'd3, 20'h01C00, 4'd12, 3'b110, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{6'b001000, 6'b000000, 1'b0, 4'd4, 20'h019A0, 4'd10, 3'b010, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{6'b000010, 6'b000000, 1'b0, 4'd3, 20'h01B00, 4'd11, 3'b010, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{6'b111111, 6'b000000, 1'b0, 4'd2, 20'h01000, 4'd1,  3'b010, 1'b0, 1'b0, 1'b0};

    // Reset held: FETCH outputs must be visible.
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_state", state, 4'd0);
    checkOutput("reset_outputs", w_bundle, 15'b001100000100010);
    @(negedge clk);
    reset = 1'b1;

    // Directed vector table.
    foreach (vecs[v]) begin
      applyStimulus(vecs[v].op, vecs[v].funct);
      zero = vecs[v].zero;
      for (int i = 0; i < int'(vecs[v].n); i++) begin
        #1;
        expSt = vecs[v].seq[19-4*i -: 4];
        checkOutput("vec_state", state, expSt);
        if (expSt == vecs[v].keySt) begin
          checkOutput("vec_alucontrol", alucontrol, vecs[v].keyAlu);
          checkOutput("vec_pcen", pcen, vecs[v].keyPcen);
          checkOutput("vec_regwrite", regwrite, vecs[v].keyRw);
          checkOutput("vec_memwrite", memwrite, vecs[v].keyMw);
        end
        @(negedge clk);
      end
    end
    #1;
    checkOutput("vec_back_to_fetch", state, 4'd0);

    // bne with the decoder disabled falls straight back to FETCH.
    doReset();
    applyStimulus(6'b000101, 6'b000000);
    zero = 1'b0;
    #1;
    checkOutput("bne_off_fetch", state0, 4'd0);
    @(negedge clk);
    #1;
    checkOutput("bne_off_decode", state0, 4'd1);
    @(negedge clk);
    #1;
    checkOutput("bne_off_return", state0, 4'd0);
    checkOutput("bne_off_no_branch_pcsrc", pcsrc0, 2'b00);

    // Reset asserted mid-store.
    doReset();
    applyStimulus(6'b101011, 6'b000000);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("sw_in_memwr", state, 4'd5);
    checkOutput("sw_memwrite", memwrite, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("reset_from_memwr_state", state, 4'd0);
    checkOutput("reset_from_memwr_memwrite", memwrite, 1'b0);
    checkOutput("reset_from_memwr_outputs", w_bundle, 15'b001100000100010);

    // Reset asserted in BEQ.
    doReset();
    applyStimulus(6'b000100, 6'b000000);
    zero = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("beq_state", state, 4'd8);
    checkOutput("beq_pcen", pcen, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("reset_from_beq_state", state, 4'd0);

    // Illegal state code recovers to FETCH with no strobes while there.
    doReset();
    applyStimulus(6'b000000, 6'b100000);
    force dut.r_state = 4'd14;
    #1;
    checkOutput("forced_state", state, 4'd14);
    checkOutput("forced_outputs", w_bundle, 15'b000000000000010);
    release dut.r_state;
    @(negedge clk);
    #1;
    checkOutput("forced_recovery", state, 4'd0);

    // Random instruction stream against the model.
    doReset();
    for (int k = 0; k < 300; k++) begin
      logic [5:0] o;
      logic [5:0] f;
      case ($urandom_range(0, 7))
        0: o = 6'b100011;
        1: o = 6'b101011;
        2: o = 6'b000000;
        3: o = 6'b000100;
        4: o = 6'b000101;
        5: o = 6'b001000;
        6: o = 6'b000010;
        default: o = 6'($urandom_range(0, 63));
      endcase
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : functList[$urandom_range(0, 6)];
      runInstr(o, f, 2);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
